// File: rtl/countdown_pkg.sv
// Shared types and limits for the two-digit BCD countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> DIGIT_MAX and flags the wrap on bout.
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter logic [3:0] DIGIT_MAX = ONES_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       dec,
    output logic [3:0] q,
    output logic       bout
);

    logic [3:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 4'd0;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (dec) begin
            r_q <= (r_q == 4'd0) ? DIGIT_MAX : r_q - 4'd1;
        end
    end

    assign q    = r_q;
    assign bout = dec && (r_q == 4'd0);

endmodule

// File: rtl/countdown_mod60.sv
// Two-digit BCD countdown (00..59) with shadow reload, pause/resume and done/borrow pulses.
module countdown_mod60
    import countdown_pkg::*;
#(
    parameter logic AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic [3:0] cnt_ones,
    output logic [3:0] cnt_tens,
    output logic       busy,
    output logic       borrow,
    output logic       done
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_shadow_ones;
    logic [3:0] r_shadow_tens;
    logic       r_busy;
    logic       r_borrow;
    logic       r_done;

    logic [3:0] w_ones;
    logic [3:0] w_tens;
    logic       w_ones_bout;
    logic       w_tens_bout;
    logic       w_ld;
    logic [3:0] w_ld_ones;
    logic [3:0] w_ld_tens;
    logic       w_dec;
    logic       w_done_nxt;
    logic       w_zero;
    logic       w_last;
    logic       w_shadow_zero;

    assign w_zero        = (w_ones == 4'd0) && (w_tens == 4'd0);
    assign w_last        = (w_ones == 4'd1) && (w_tens == 4'd0);
    assign w_shadow_zero = (r_shadow_ones == 4'd0) && (r_shadow_tens == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_ld_ones   = r_shadow_ones;
        w_ld_tens   = r_shadow_tens;
        w_dec       = 1'b0;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_state_nxt = ST_IDLE;
            w_ld        = 1'b1;
            w_ld_ones   = clamp_digit(load_ones, ONES_MAX);
            w_ld_tens   = clamp_digit(load_tens, TENS_MAX);
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_zero) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (tick) begin
                        // Sitting at 00 in RUN only happens in auto-reload mode: this tick restarts the period.
                        if (w_zero) begin
                            if (AUTO_RELOAD) w_ld = 1'b1;
                            else             w_state_nxt = ST_DONE;
                        end else begin
                            w_dec = 1'b1;
                            if (w_last) begin
                                w_done_nxt = 1'b1;
                                if (!AUTO_RELOAD) w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) w_state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    if (start) begin
                        w_ld = 1'b1;
                        if (w_shadow_zero) w_done_nxt  = 1'b1;
                        else               w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    bcd_down_digit #(.DIGIT_MAX(ONES_MAX)) u_ones (
        .clk    (clk),
        .rst    (rst),
        .ld     (w_ld),
        .ld_val (w_ld_ones),
        .dec    (w_dec),
        .q      (w_ones),
        .bout   (w_ones_bout)
    );

    bcd_down_digit #(.DIGIT_MAX(TENS_MAX)) u_tens (
        .clk    (clk),
        .rst    (rst),
        .ld     (w_ld),
        .ld_val (w_ld_tens),
        .dec    (w_ones_bout),
        .q      (w_tens),
        .bout   (w_tens_bout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_shadow_ones <= 4'd0;
            r_shadow_tens <= 4'd0;
            r_busy        <= 1'b0;
            r_borrow      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
            r_borrow <= w_ones_bout && !w_tens_bout;
            r_done   <= w_done_nxt;
            if (load) begin
                r_shadow_ones <= w_ld_ones;
                r_shadow_tens <= w_ld_tens;
            end
        end
    end

    assign cnt_ones = w_ones;
    assign cnt_tens = w_tens;
    assign busy     = r_busy;
    assign borrow   = r_borrow;
    assign done     = r_done;

endmodule

// File: tb/tb_countdown_mod60.sv
// Bench for countdown_mod60: both AUTO_RELOAD variants share stimulus and are checked against a decimal model.
module tb_countdown_mod60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, load, start, pause, tick;
    logic [3:0] load_ones, load_tens;
    logic [3:0] ones0, tens0, ones1, tens1;
    logic       busy0, borrow0, done0, busy1, borrow1, done1;

    countdown_mod60 #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load(load), .load_ones(load_ones), .load_tens(load_tens),
        .start(start), .pause(pause), .tick(tick),
        .cnt_ones(ones0), .cnt_tens(tens0), .busy(busy0), .borrow(borrow0), .done(done0)
    );

    countdown_mod60 #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_ones(load_ones), .load_tens(load_tens),
        .start(start), .pause(pause), .tick(tick),
        .cnt_ones(ones1), .cnt_tens(tens1), .busy(busy1), .borrow(borrow1), .done(done1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode[2];
    int m_cnt[2];
    int m_shadow[2];
    bit m_borrow[2];
    bit m_done[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_cnt[i] = 0; m_shadow[i] = 0;
            m_borrow[i] = 0; m_done[i] = 0;
        end
    endtask

    // Instance i has AUTO_RELOAD = i; the count is kept as a plain integer 0..59.
    task automatic model_edge();
        int lt, lo;
        if (!rst) return;
        for (int i = 0; i < 2; i++) begin
            m_borrow[i] = 0;
            m_done[i]   = 0;
            if (load) begin
                lt = int'(load_tens); if (lt > 5) lt = 5;
                lo = int'(load_ones); if (lo > 9) lo = 9;
                m_cnt[i] = lt * 10 + lo;
                m_shadow[i] = m_cnt[i];
                m_mode[i] = M_IDLE;
            end else begin
                case (m_mode[i])
                    M_IDLE: if (start) begin
                        if (m_cnt[i] == 0) begin m_mode[i] = M_DONE; m_done[i] = 1; end
                        else m_mode[i] = M_RUN;
                    end
                    M_RUN: if (pause) m_mode[i] = M_PAUSE;
                        else if (tick) begin
                            if (m_cnt[i] == 0) begin
                                if (i == 1) m_cnt[i] = m_shadow[i];
                                else m_mode[i] = M_DONE;
                            end else begin
                                if (m_cnt[i] % 10 == 0) m_borrow[i] = 1;
                                m_cnt[i] = m_cnt[i] - 1;
                                if (m_cnt[i] == 0) begin
                                    m_done[i] = 1;
                                    if (i == 0) m_mode[i] = M_DONE;
                                end
                            end
                        end
                    M_PAUSE: if (start) m_mode[i] = M_RUN;
                    default: if (start) begin
                        m_cnt[i] = m_shadow[i];
                        if (m_cnt[i] == 0) m_done[i] = 1;
                        else m_mode[i] = M_RUN;
                    end
                endcase
            end
        end
    endtask

    function automatic logic [10:0] exp_vec(int i);
        logic [3:0] t, o;
        logic b;
        t = 4'(m_cnt[i] / 10);
        o = 4'(m_cnt[i] % 10);
        b = (m_mode[i] == M_RUN) || (m_mode[i] == M_PAUSE);
        return {t, o, b, m_borrow[i], m_done[i]};
    endfunction

    function automatic logic [10:0] dut_vec(int i);
        if (i == 0) return {tens0, ones0, busy0, borrow0, done0};
        return {tens1, ones1, busy1, borrow1, done1};
    endfunction

    task automatic cyc(input logic l, input logic [3:0] lt, input logic [3:0] lo,
                       input logic s, input logic p, input logic t);
        load = l; load_tens = lt; load_ones = lo; start = s; pause = p; tick = t;
        @(posedge clk);
        model_edge();
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_vec(i) !== 11'd0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got %h want %h", i, dut_vec(i), 11'd0);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_decrement();
        logic [7:0] want_cnt[3];
        logic       want_brw[3];
        want_cnt = '{8'h11, 8'h10, 8'h09};
        want_brw = '{1'b0, 1'b0, 1'b1};
        cyc(1, 4'd1, 4'd2, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 1);
            n_cmp++;
            if ({tens0, ones0, borrow0, busy0} !== {want_cnt[k], want_brw[k], 1'b1}) begin
                n_bad++;
                $display("FAIL decrement tick%0d: got %h%h brw=%b busy=%b want %h brw=%b busy=1",
                         k, tens0, ones0, borrow0, busy0, want_cnt[k], want_brw[k]);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (borrow0 !== 1'b0) begin
            n_bad++;
            $display("FAIL borrow_width: got %b want 0", borrow0);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_vec(i) !== exp_vec(i)) begin
                n_bad++;
                $display("FAIL decrement_model dut%0d: got %h want %h", i, dut_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_done();
        cyc(1, 4'd0, 4'd1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if ({tens0, ones0, done0, busy0} !== {8'h00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL done_pulse: got %h%h done=%b busy=%b want 00 done=1 busy=0",
                     tens0, ones0, done0, busy0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 1);
            n_cmp++;
            if ({tens0, ones0, done0, busy0} !== 11'd0) begin
                n_bad++;
                $display("FAIL done_hold%0d: got %h%h done=%b busy=%b want 00 0 0",
                         k, tens0, ones0, done0, busy0);
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    n_bad++;
                    $display("FAIL done_model dut%0d: got %h want %h", i, dut_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_auto_reload();
        int n_done = 0;
        int n_brw = 0;
        cyc(1, 4'd5, 4'd9, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 120; k++) begin
            cyc(0, 0, 0, 0, 0, 1);
            if (done1) n_done++;
            if (borrow1) n_brw++;
            n_cmp++;
            if (dut_vec(1) !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL reload_model tick%0d: got %h want %h", k, dut_vec(1), exp_vec(1));
            end
            if (k == 60) begin
                n_cmp++;
                if ({tens1, ones1, borrow1} !== {8'h59, 1'b0}) begin
                    n_bad++;
                    $display("FAIL reload_period: got %h%h brw=%b want 59 brw=0", tens1, ones1, borrow1);
                end
            end
        end
        n_cmp++;
        if (n_done != 2 || n_brw != 10) begin
            n_bad++;
            $display("FAIL reload_pulses: got done=%0d borrow=%0d want done=2 borrow=10", n_done, n_brw);
        end
    endtask

    task automatic test_pause();
        cyc(1, 4'd3, 4'd0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 0, 1);
            n_cmp++;
            if ({tens0, ones0, busy0} !== {8'h28, 1'b1}) begin
                n_bad++;
                $display("FAIL pause_hold%0d: got %h%h busy=%b want 28 busy=1", k, tens0, ones0, busy0);
            end
        end
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if ({tens0, ones0} !== 8'h27) begin
            n_bad++;
            $display("FAIL pause_resume: got %h%h want 27", tens0, ones0);
        end
    endtask

    task automatic test_load_edges();
        cyc(1, 4'd7, 4'hF, 0, 0, 0);
        n_cmp++;
        if ({tens0, ones0, busy0} !== {8'h59, 1'b0}) begin
            n_bad++;
            $display("FAIL load_clamp: got %h%h busy=%b want 59 busy=0", tens0, ones0, busy0);
        end
        cyc(1, 4'd2, 4'd5, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if ({tens0, ones0, busy0, tens1, ones1, busy1} !== {8'h25, 1'b0, 8'h25, 1'b0}) begin
            n_bad++;
            $display("FAIL load_priority: got %h%h/%b %h%h/%b want 25/0 25/0",
                     tens0, ones0, busy0, tens1, ones1, busy1);
        end
        cyc(1, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({tens0, ones0, done0, done1} !== {8'h00, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL start_zero: got %h%h done=%b/%b want 00 done=1/1", tens0, ones0, done0, done1);
        end
        cyc(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if ({tens0, ones0, borrow0, done0, tens1, ones1} !== {8'h00, 2'b00, 8'h00}) begin
            n_bad++;
            $display("FAIL no_underflow: got %h%h brw=%b done=%b %h%h want 00 0 0 00",
                     tens0, ones0, borrow0, done0, tens1, ones1);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 4'd3, 4'd5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if ({tens0, ones0} !== 8'h34) begin
            n_bad++;
            $display("FAIL reset_mid_setup: got %h%h want 34", tens0, ones0);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dut_vec(i) !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_async dut%0d: got %h want %h", i, dut_vec(i), 11'd0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({tens0, ones0, done0, done1, busy0} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_then_start: got %h%h done=%b/%b busy=%b want 00 1/1 0",
                     tens0, ones0, done0, done1, busy0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 0));
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    n_bad++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", i, k, dut_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        load_ones = 4'd0; load_tens = 4'd0;
        test_reset();
        test_decrement();
        test_done();
        test_auto_reload();
        test_pause();
        test_load_edges();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
